// File: rtl/wb2ahb.sv
// Wishbone classic slave to AHB master bridge: one NONSEQ SINGLE word transfer per Wishbone cycle, status returned as a registered pulse.
// Three edges strobe-to-ack when unstalled; each cycle without hgrant or hready adds one, and RETRY/SPLIT re-arbitrate up to MAX_RETRY times.
module wb2ahb #(
  parameter int AWIDTH    = 32,
  parameter int DWIDTH    = 32,
  parameter int MAX_RETRY = 15
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic [AWIDTH-1:0] adr_i,
  input  logic [DWIDTH-1:0] dat_i,
  output logic [DWIDTH-1:0] dat_o,
  input  logic              we_i,
  input  logic              cyc_i,
  input  logic              stb_i,
  output logic              ack_o,
  output logic              err_o,
  output logic              hbusreq,
  input  logic              hgrant,
  output logic [AWIDTH-1:0] haddr,
  output logic [1:0]        htrans,
  output logic              hwrite,
  output logic [2:0]        hsize,
  output logic [2:0]        hburst,
  output logic [DWIDTH-1:0] hwdata,
  input  logic [DWIDTH-1:0] hrdata,
  input  logic              hready,
  input  logic [1:0]        hresp
);
  typedef enum logic [2:0] {IDLE, REQ, ADDR, DATA, ACK} state_t;

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [1:0] RESP_ERROR   = 2'b01;
  localparam logic [3:0] RETRY_LIMIT  = 4'(MAX_RETRY);

  state_t            state;
  logic [AWIDTH-1:0] lat_adr;
  logic [DWIDTH-1:0] lat_dat;
  logic              lat_we;
  logic [3:0]        retry_cnt;
  logic              abandoned;
  logic              live;

  assign hsize  = 3'b010;
  assign hburst = 3'b000;
  // A master that drops cyc_i at any point of the transfer gets no termination.
  assign live   = cyc_i && !abandoned;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state     <= IDLE;
      hbusreq   <= 1'b0;
      htrans    <= TRANS_IDLE;
      haddr     <= '0;
      hwrite    <= 1'b0;
      hwdata    <= '0;
      dat_o     <= '0;
      ack_o     <= 1'b0;
      err_o     <= 1'b0;
      retry_cnt <= '0;
      lat_adr   <= '0;
      lat_dat   <= '0;
      lat_we    <= 1'b0;
      abandoned <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cyc_i && stb_i) begin
            lat_adr   <= adr_i;
            lat_dat   <= dat_i;
            lat_we    <= we_i;
            hbusreq   <= 1'b1;
            retry_cnt <= '0;
            abandoned <= 1'b0;
            state     <= REQ;
          end
        end
        REQ: begin
          if (!cyc_i) abandoned <= 1'b1;
          if (hgrant && hready) begin
            htrans <= TRANS_NONSEQ;
            haddr  <= lat_adr;
            hwrite <= lat_we;
            state  <= ADDR;
          end
        end
        ADDR: begin
          if (!cyc_i) abandoned <= 1'b1;
          if (hready) begin
            htrans  <= TRANS_IDLE;
            hbusreq <= 1'b0;
            hwdata  <= lat_dat;
            state   <= DATA;
          end
        end
        DATA: begin
          if (!cyc_i) abandoned <= 1'b1;
          // The first cycle of a two-cycle response has hready low and needs nothing: htrans is already IDLE.
          if (hready) begin
            case (hresp)
              RESP_OKAY: begin
                ack_o <= live;
                if (!lat_we) dat_o <= hrdata;
                state <= ACK;
              end
              RESP_ERROR: begin
                err_o <= live;
                state <= ACK;
              end
              default: begin
                if (retry_cnt < RETRY_LIMIT) begin
                  retry_cnt <= retry_cnt + 4'd1;
                  hbusreq   <= 1'b1;
                  state     <= REQ;
                end else begin
                  err_o <= live;
                  state <= ACK;
                end
              end
            endcase
          end
        end
        ACK: begin
          ack_o <= 1'b0;
          err_o <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb2ahb.sv
// Bench for wb2ahb: a scripted AHB arbiter/slave driven per attempt, checked against a transaction-level outcome and latency model.
module tb_wb2ahb;
  localparam int TB_MAX = 2;
  localparam logic [1:0] OKAY = 2'b00, ERROR = 2'b01, RETRY = 2'b10, SPLIT = 2'b11;

  logic        hclk = 1'b0, hresetn = 1'b0;
  logic [31:0] adr_i = '0, dat_i = '0, dat_o, haddr, hwdata, hrdata = '0;
  logic        we_i = 1'b0, cyc = 1'b0, stb = 1'b0, ack_o, err_o;
  logic        hbusreq, hgrant = 1'b0, hwrite, hready = 1'b1;
  logic [1:0]  htrans, hresp = 2'b00;
  logic [2:0]  hsize, hburst;

  int          n_chk = 0, n_fail = 0;
  int          att_g[8], att_a[8], att_d[8];
  logic [1:0]  att_resp[8];
  logic [31:0] model_dato = '0;

  wb2ahb #(.AWIDTH(32), .DWIDTH(32), .MAX_RETRY(TB_MAX)) dut (
    .hclk(hclk), .hresetn(hresetn), .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o),
    .we_i(we_i), .cyc_i(cyc), .stb_i(stb), .ack_o(ack_o), .err_o(err_o),
    .hbusreq(hbusreq), .hgrant(hgrant), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
    .hsize(hsize), .hburst(hburst), .hwdata(hwdata), .hrdata(hrdata), .hready(hready), .hresp(hresp)
  );

  always #5 hclk = ~hclk;

  task automatic set_att(input int i, input int g, input int a, input int d, input logic [1:0] r);
    att_g[i] = g; att_a[i] = a; att_d[i] = d; att_resp[i] = r;
  endtask

  // One Wishbone cycle; the AHB side follows the attempt tables, the model predicts outcome, latency and dat_o.
  task automatic run_xfer(input string tag, input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [31:0] rd, input bit drop, input int n_att, input bit rst_mid);
    int retries, used, lat, att, sph, left, gleft, cnt;
    bit exp_ack, exp_err, done;
    logic [31:0] exp_dato;
    retries = 0; used = 0; lat = 0; exp_ack = 0; exp_err = 0; exp_dato = model_dato;
    for (int i = 0; i < n_att; i++) begin
      used++;
      lat += att_g[i] + att_a[i] + att_d[i] + 3;
      if (att_resp[i] == OKAY) begin exp_ack = 1; if (!we) exp_dato = rd; break; end
      if (att_resp[i] == ERROR) begin exp_err = 1; break; end
      if (retries >= TB_MAX) begin exp_err = 1; break; end
      retries++;
    end
    if (drop) begin exp_ack = 0; exp_err = 0; end

    cyc = 1; stb = 1; we_i = we; adr_i = adr; dat_i = dat;
    hgrant = 0; hready = 1; hresp = OKAY;
    att = 0; sph = 0; left = 0; gleft = att_g[0]; cnt = 0; done = 0;
    while (!done) begin
      @(posedge hclk); cnt++;
      @(negedge hclk);
      if (cnt > 400) begin
        n_chk++; n_fail++; done = 1;
        $display("FAIL %s timeout: still running after %0d cycles, required termination", tag, cnt);
      end else if (ack_o || err_o) begin
        done = 1;
        if (drop) begin
          n_chk++; n_fail++;
          $display("FAIL %s suppress: ack=%b err=%b, required 0 0", tag, ack_o, err_o);
        end else begin
          n_chk++;
          if (ack_o !== exp_ack || err_o !== exp_err) begin
            n_fail++; $display("FAIL %s status: ack=%b err=%b, required %b %b", tag, ack_o, err_o, exp_ack, exp_err);
          end
          n_chk++;
          if (cnt - 1 != lat) begin
            n_fail++; $display("FAIL %s latency: %0d edges, required %0d", tag, cnt - 1, lat);
          end
        end
        n_chk++;
        if (dat_o !== exp_dato) begin
          n_fail++; $display("FAIL %s dat_o: %h, required %h", tag, dat_o, exp_dato);
        end
        @(posedge hclk); @(negedge hclk);
        n_chk++;
        if (ack_o !== 1'b0 || err_o !== 1'b0 || hbusreq !== 1'b0) begin
          n_fail++; $display("FAIL %s pulse_end: ack=%b err=%b hbusreq=%b, required 0 0 0", tag, ack_o, err_o, hbusreq);
        end
        cyc = 0; stb = 0;
      end else if (rst_mid && sph == 2) begin
        #2 hresetn = 0;
        #1;
        n_chk++;
        if ({hbusreq, htrans, haddr, hwrite, hwdata, dat_o, ack_o, err_o} !== '0) begin
          n_fail++; $display("FAIL %s async_reset: hbusreq=%b htrans=%b haddr=%h hwdata=%h dat_o=%h ack=%b err=%b, required all 0",
                             tag, hbusreq, htrans, haddr, hwdata, dat_o, ack_o, err_o);
        end
        cyc = 0; stb = 0; hgrant = 0; hready = 1; hresp = OKAY;
        @(posedge hclk); @(negedge hclk);
        hresetn = 1; exp_dato = '0; done = 1;
      end else begin
        if (sph == 3) begin
          att = (att < 7) ? att + 1 : 7;
          sph = 0; gleft = att_g[att];
          if (drop && att >= used) done = 1;
        end
        if (sph == 0 && htrans == 2'b10) begin
          n_chk++;
          if (haddr !== adr || hwrite !== we) begin
            n_fail++; $display("FAIL %s addr_phase: haddr=%h hwrite=%b, required %h %b", tag, haddr, hwrite, adr, we);
          end
          if (att == 0) begin
            n_chk++;
            if (cnt != att_g[0] + 2) begin
              n_fail++; $display("FAIL %s nonseq_time: edge %0d, required %0d", tag, cnt - 1, att_g[0] + 1);
            end
          end
          sph = 1; left = att_a[att];
        end else if (sph == 1) begin
          n_chk++;
          if (htrans !== 2'b10 || haddr !== adr || hwrite !== we) begin
            n_fail++; $display("FAIL %s addr_hold: htrans=%b haddr=%h, required 10 %h", tag, htrans, haddr, adr);
          end
        end
        if (sph == 2) begin
          n_chk++;
          if (htrans !== 2'b00 || (we && hwdata !== dat)) begin
            n_fail++; $display("FAIL %s data_phase: htrans=%b hwdata=%h, required 00 %h", tag, htrans, hwdata, dat);
          end
          if (drop) begin cyc = 0; stb = 0; end
        end
        case (sph)
          0: begin
            hready = 1; hresp = OKAY;
            hgrant = hbusreq && (gleft == 0);
            if (hbusreq && gleft > 0) gleft--;
          end
          1: begin
            hgrant = 0; hresp = OKAY;
            if (left > 0) begin hready = 0; left--; end
            else begin hready = 1; sph = 2; left = att_d[att]; end
          end
          2: begin
            if (left > 0) begin
              hready = 0; hresp = (left == 1) ? att_resp[att] : OKAY; hrdata = $urandom; left--;
            end else begin
              hready = 1; hresp = att_resp[att];
              hrdata = (att_resp[att] == OKAY) ? rd : $urandom;
              sph = 3;
            end
          end
          default: ;
        endcase
      end
    end
    if (drop) begin
      for (int k = 0; k < 3; k++) begin
        @(posedge hclk); @(negedge hclk);
        n_chk++;
        if (ack_o !== 1'b0 || err_o !== 1'b0) begin
          n_fail++; $display("FAIL %s drop_quiet: ack=%b err=%b, required 0 0", tag, ack_o, err_o);
        end
      end
      n_chk++;
      if (hbusreq !== 1'b0 || htrans !== 2'b00 || dat_o !== exp_dato) begin
        n_fail++; $display("FAIL %s drop_idle: hbusreq=%b htrans=%b dat_o=%h, required 0 00 %h", tag, hbusreq, htrans, dat_o, exp_dato);
      end
    end
    model_dato = exp_dato;
  endtask

  task automatic test_reset;
    hresetn = 0;
    #3;
    n_chk++;
    if ({hbusreq, htrans, haddr, hwrite, hwdata, dat_o, ack_o, err_o} !== '0 || hsize !== 3'b010 || hburst !== 3'b000) begin
      n_fail++; $display("FAIL reset_state: hbusreq=%b htrans=%b ack=%b err=%b hsize=%b hburst=%b, required 0 00 0 0 010 000",
                         hbusreq, htrans, ack_o, err_o, hsize, hburst);
    end
    repeat (2) @(negedge hclk);
    hresetn = 1;
    repeat (3) begin
      @(posedge hclk); @(negedge hclk);
      n_chk++;
      if (hbusreq !== 1'b0 || ack_o !== 1'b0 || err_o !== 1'b0) begin
        n_fail++; $display("FAIL reset_idle: hbusreq=%b ack=%b err=%b, required 0 0 0", hbusreq, ack_o, err_o);
      end
    end
  endtask

  task automatic test_zero_wait_write;
    set_att(0, 0, 0, 0, OKAY);
    run_xfer("zero_wait_write", 1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0, 0, 1, 0);
  endtask

  task automatic test_wait_read;
    set_att(0, 3, 0, 2, OKAY);
    run_xfer("wait_read", 1'b0, 32'h0000_2004, 32'h0, 32'h1234_5678, 0, 1, 0);
  endtask

  task automatic test_error;
    set_att(0, 0, 0, 1, ERROR);
    run_xfer("error_resp", 1'b0, 32'h0000_3000, 32'h0, 32'hBAD0_BAD0, 0, 1, 0);
  endtask

  task automatic test_retry;
    set_att(0, 0, 0, 1, RETRY);
    set_att(1, 1, 1, 1, SPLIT);
    set_att(2, 0, 0, 0, OKAY);
    run_xfer("retry_ok", 1'b1, 32'h0000_4008, 32'hCAFE_F00D, 32'h0, 0, 3, 0);
  endtask

  task automatic test_retry_limit;
    for (int i = 0; i < 3; i++) set_att(i, 0, 0, 1, RETRY);
    set_att(3, 0, 0, 0, OKAY);
    run_xfer("retry_limit", 1'b0, 32'h0000_500C, 32'h0, 32'h5555_AAAA, 0, 4, 0);
  endtask

  task automatic test_cyc_drop;
    set_att(0, 1, 0, 2, OKAY);
    run_xfer("cyc_drop", 1'b0, 32'h0000_6000, 32'h0, 32'h0BAD_CAFE, 1, 1, 0);
    set_att(0, 0, 0, 0, OKAY);
    run_xfer("after_drop", 1'b1, 32'h0000_6004, 32'h1111_2222, 32'h0, 0, 1, 0);
  endtask

  task automatic test_reset_mid_data;
    set_att(0, 0, 0, 3, OKAY);
    run_xfer("reset_mid", 1'b1, 32'h0000_7000, 32'h7777_7777, 32'h0, 0, 1, 1);
    repeat (3) begin
      @(posedge hclk); @(negedge hclk);
      n_chk++;
      if (hbusreq !== 1'b0 || ack_o !== 1'b0 || err_o !== 1'b0 || htrans !== 2'b00) begin
        n_fail++; $display("FAIL reset_mid_idle: hbusreq=%b htrans=%b ack=%b err=%b, required 0 00 0 0", hbusreq, htrans, ack_o, err_o);
      end
    end
    set_att(0, 0, 0, 0, OKAY);
    run_xfer("after_reset", 1'b0, 32'h0000_7004, 32'h0, 32'h89AB_CDEF, 0, 1, 0);
  endtask

  task automatic test_back_to_back;
    for (int t = 0; t < 30; t++) begin
      int n;
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        att_g[i] = $urandom_range(0, 2);
        att_a[i] = $urandom_range(0, 2);
        att_d[i] = $urandom_range(0, 2);
        if (i < n - 1) att_resp[i] = ($urandom_range(0, 1) == 1) ? RETRY : SPLIT;
        else           att_resp[i] = ($urandom_range(0, 3) == 0) ? ERROR : OKAY;
      end
      run_xfer("random", 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
               ($urandom_range(0, 7) == 0), n, 0);
    end
  endtask

  initial begin
    test_reset;
    test_zero_wait_write;
    test_wait_read;
    test_error;
    test_retry;
    test_retry_limit;
    test_cyc_drop;
    test_reset_mid_data;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
